// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and encodings for the ARM pipeline hazard controller.
// Holds the FSM state enum, forwarding selects and the PC register number.
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_LD = 2'd1,
    STALL_FL = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  localparam logic [3:0] REG_PC = 4'd15;

  localparam logic [2:0] RUN_MAX = 3'd7;

  // Saturating increment for the stall run counter.
  function automatic logic [2:0] run_inc(
    input logic [2:0] v
  );
    return (v == RUN_MAX) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of the hazard controller's pipeline-facing signals.
// The pipeline side uses master; the controller uses slave.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);

  logic [3:0]       id_rn;
  logic [3:0]       id_rm;
  logic [3:0]       id_rd;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rd;
  logic             id_cond;
  logic             branch_taken;
  logic [3:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic             ex_set_flags;
  logic [3:0]       mem_rd;
  logic             mem_reg_write;
  logic [3:0]       wb_rd;
  logic             wb_reg_write;
  logic             clr_counters;

  logic             pc_enable;
  logic             if_id_enable;
  logic             if_id_flush;
  logic             nop_insert;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       fwd_c;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;
  logic             stall_error;

  modport master (
    output id_rn, id_rm, id_rd,
    output id_use_rn, id_use_rm, id_use_rd,
    output id_cond, branch_taken,
    output ex_rd, ex_reg_write,
    output ex_mem_to_reg, ex_set_flags,
    output mem_rd, mem_reg_write,
    output wb_rd, wb_reg_write,
    output clr_counters,
    input  pc_enable, if_id_enable,
    input  if_id_flush, nop_insert,
    input  fwd_a, fwd_b, fwd_c,
    input  stall_cycles, flush_cycles,
    input  stall_error
  );

  modport slave (
    input  id_rn, id_rm, id_rd,
    input  id_use_rn, id_use_rm, id_use_rd,
    input  id_cond, branch_taken,
    input  ex_rd, ex_reg_write,
    input  ex_mem_to_reg, ex_set_flags,
    input  mem_rd, mem_reg_write,
    input  wb_rd, wb_reg_write,
    input  clr_counters,
    output pc_enable, if_id_enable,
    output if_id_flush, nop_insert,
    output fwd_a, fwd_b, fwd_c,
    output stall_cycles, flush_cycles,
    output stall_error
  );

endinterface

// File: rtl/pipeline_hazard_controller_forward_select.sv
// Operand forwarding select for one ID source register.
// Youngest producer wins; R15 and unused sources read the regfile.
module forward_select
  import ctrl_pkg::*;
(
  input  logic [3:0] i_src,
  input  logic       i_use,
  input  logic [3:0] i_exmem_rd,
  input  logic       i_exmem_we,
  input  logic [3:0] i_memwb_rd,
  input  logic       i_memwb_we,
  input  logic [3:0] i_wb_rd,
  input  logic       i_wb_we,
  output logic [1:0] o_sel
);

  logic w_ok;

  assign w_ok = i_use & (i_src != REG_PC);

  // Priority pick of the youngest matching writer.
  always_comb begin
    o_sel = FWD_RF;
    if (w_ok && i_exmem_we && i_exmem_rd == i_src)
      o_sel = FWD_EXMEM;
    else if (w_ok && i_memwb_we && i_memwb_rd == i_src)
      o_sel = FWD_MEMWB;
    else if (w_ok && i_wb_we && i_wb_rd == i_src)
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage ARM pipeline hazard controller: stalls, flushes,
// forwarding selects, saturating perf counters and stall watchdog.
module pipeline_hazard_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 4
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_controller_if.slave bus
);

  logic       w_ex_load;
  logic       w_hit_rn;
  logic       w_hit_rm;
  logic       w_hit_rd;
  logic       w_load_hz;
  logic       w_flag_hz;
  logic       w_stall;
  logic       w_flush;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_run_cnt;
  logic [2:0] w_run_next;
  logic       r_err;
  logic       w_err_next;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic [1:0] w_sel_c;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic [1:0] r_fwd_c;

  logic [3:0] r_wb_rd;
  logic       r_wb_we;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_ex_load = bus.ex_mem_to_reg
                   & bus.ex_reg_write
                   & (bus.ex_rd != REG_PC);

  assign w_hit_rn = bus.id_use_rn
                  & (bus.id_rn == bus.ex_rd);
  assign w_hit_rm = bus.id_use_rm
                  & (bus.id_rm == bus.ex_rd);
  assign w_hit_rd = bus.id_use_rd
                  & (bus.id_rd == bus.ex_rd);

  assign w_load_hz = w_ex_load
                   & (w_hit_rn | w_hit_rm | w_hit_rd);
  assign w_flag_hz = bus.ex_set_flags & bus.id_cond;
  assign w_stall   = w_load_hz | w_flag_hz;

  // A stale-flag branch is dropped while stalled.
  assign w_flush = ~reset & bus.branch_taken & ~w_stall;

  forward_select u_fwd_rn (
    .i_src      (bus.id_rn),
    .i_use      (bus.id_use_rn),
    .i_exmem_rd (bus.mem_rd),
    .i_exmem_we (bus.mem_reg_write),
    .i_memwb_rd (bus.wb_rd),
    .i_memwb_we (bus.wb_reg_write),
    .i_wb_rd    (r_wb_rd),
    .i_wb_we    (r_wb_we),
    .o_sel      (w_sel_a)
  );

  forward_select u_fwd_rm (
    .i_src      (bus.id_rm),
    .i_use      (bus.id_use_rm),
    .i_exmem_rd (bus.mem_rd),
    .i_exmem_we (bus.mem_reg_write),
    .i_memwb_rd (bus.wb_rd),
    .i_memwb_we (bus.wb_reg_write),
    .i_wb_rd    (r_wb_rd),
    .i_wb_we    (r_wb_we),
    .o_sel      (w_sel_b)
  );

  forward_select u_fwd_rd (
    .i_src      (bus.id_rd),
    .i_use      (bus.id_use_rd),
    .i_exmem_rd (bus.mem_rd),
    .i_exmem_we (bus.mem_reg_write),
    .i_memwb_rd (bus.wb_rd),
    .i_memwb_we (bus.wb_reg_write),
    .i_wb_rd    (r_wb_rd),
    .i_wb_we    (r_wb_we),
    .o_sel      (w_sel_c)
  );

  // Next state, stall run length and watchdog.
  always_comb begin
    w_state_next = RUN;
    w_run_next   = 3'd0;
    if (w_load_hz)
      w_state_next = STALL_LD;
    else if (w_flag_hz)
      w_state_next = STALL_FL;
    if (w_state_next != RUN) begin
      if (r_state == RUN)
        w_run_next = 3'd1;
      else
        w_run_next = run_inc(r_run_cnt);
    end
    w_err_next = r_err
               | (int'(w_run_next) >= MAX_STALL);
  end

  // State, run counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_run_cnt <= 3'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_next;
      r_err     <= w_err_next;
    end
  end

  // ID/EX forwarding selects; a bubble carries 00.
  always_ff @(posedge clk) begin
    if (reset || w_stall) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
      r_fwd_c <= FWD_RF;
    end else begin
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
      r_fwd_c <= w_sel_c;
    end
  end

  // Remember last cycle's write-back for the WB bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_rd <= 4'd0;
      r_wb_we <= 1'b0;
    end else begin
      r_wb_rd <= bus.wb_rd;
      r_wb_we <= bus.wb_reg_write;
    end
  end

  // Saturating stall counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (reset || bus.clr_counters)
      r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  // Saturating flush counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (reset || bus.clr_counters)
      r_flush_cnt <= '0;
    else if (w_flush && !(&r_flush_cnt))
      r_flush_cnt <= r_flush_cnt + CNT_W'(1);
  end

  // Output drive; reset forces the idle/bubble pattern.
  always_comb begin
    bus.pc_enable    = 1'b0;
    bus.if_id_enable = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.nop_insert   = 1'b1;
    bus.fwd_a        = FWD_RF;
    bus.fwd_b        = FWD_RF;
    bus.fwd_c        = FWD_RF;
    bus.stall_cycles = '0;
    bus.flush_cycles = '0;
    bus.stall_error  = 1'b0;
    if (!reset) begin
      bus.pc_enable    = ~w_stall;
      bus.if_id_enable = ~w_stall;
      bus.if_id_flush  = w_flush;
      bus.nop_insert   = w_stall;
      bus.fwd_a        = r_fwd_a;
      bus.fwd_b        = r_fwd_b;
      bus.fwd_c        = r_fwd_c;
      bus.stall_cycles = r_stall_cnt;
      bus.flush_cycles = r_flush_cnt;
      bus.stall_error  = r_err;
    end
  end

endmodule
